// File: rtl/game_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_seq_ctrl
// Brief    : Brick-breaker game sequencer. Generates the frame tick, runs the
//            attract/serve/play/pause/lost-life/game-over/win state machine,
//            gates paddle and ball motion and tracks lives, score and bricks.
// Options  : define HIGH_SCORE_EN to build the high-score register.
// Revision : 1.0 - initial release
// ============================================================================
module game_seq_ctrl #(
   parameter int TICK_DIV     = 833333,
   parameter int LIVES_INIT   = 3,
   parameter int BRICK_COUNT  = 40,
   parameter int SERVE_TICKS  = 120,
   parameter int HOLD_TICKS   = 60,
   parameter int BRICK_POINTS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_n,
   input  logic        pause_sw,
   input  logic        brick_hit,
   input  logic        ball_lost,
   output logic        frame_tick,
   output logic        paddle_en,
   output logic        ball_en,
   output logic        ball_reset,
   output logic [2:0]  game_state,
   output logic [2:0]  lives,
   output logic [15:0] score,
   output logic [7:0]  bricks_left,
   output logic [15:0] high_score
);

   localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_MAX = (SERVE_TICKS > HOLD_TICKS) ? SERVE_TICKS : HOLD_TICKS;
   localparam int CW      = $clog2(CNT_MAX + 2);

   localparam logic [TW-1:0] c_TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] c_SERVE     = CW'(SERVE_TICKS);
   localparam logic [CW-1:0] c_HOLD      = CW'(HOLD_TICKS);
   localparam logic [2:0]    c_LIVES     = 3'(LIVES_INIT);
   localparam logic [7:0]    c_BRICKS    = 8'(BRICK_COUNT);
   localparam logic [16:0]   c_POINTS    = 17'(BRICK_POINTS);

   typedef enum logic [2:0] {
      ST_ATTRACT = 3'd0,
      ST_SERVE   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_LOST    = 3'd4,
      ST_OVER    = 3'd5,
      ST_WIN     = 3'd6,
      ST_BAD     = 3'd7
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          frame_tick_q;
   logic          sync1_q, sync2_q, sync3_q, start_evt_q;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [2:0]    lives_q, lives_d;
   logic [15:0]   score_q, score_d, score_sat;
   logic [16:0]   score_sum;
   logic [7:0]    bricks_q, bricks_d;
   logic          ball_reset_q, ball_reset_d;
   logic          paddle_en_q, paddle_en_d;
   logic          ball_en_q, ball_en_d;

   // Free-running frame divider; the pulse marks the last count of each frame
   always_comb begin
      tick_cnt_d = (tick_cnt_q == c_TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
   end

   // Divider and frame_tick registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt_q   <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         frame_tick_q <= (tick_cnt_d == c_TICK_LAST);
      end
   end

   // Two-flop synchroniser on the button, then a registered falling-edge detect
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         sync3_q     <= 1'b1;
         start_evt_q <= 1'b0;
      end else begin
         sync1_q     <= start_n;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         start_evt_q <= sync3_q & ~sync2_q;
      end
   end

   // Serve/hold counter advance and saturating score add
   always_comb begin
      cnt_inc   = cnt_q + CW'(frame_tick_q);
      score_sum = {1'b0, score_q} + c_POINTS;
      score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   // Game state machine: next state, counters and enables
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lives_d      = lives_q;
      score_d      = score_q;
      bricks_d     = bricks_q;
      ball_reset_d = 1'b0;
      case (state_q)
         ST_ATTRACT: begin
            lives_d  = c_LIVES;
            score_d  = '0;
            bricks_d = c_BRICKS;
            if (start_evt_q) begin
               state_d      = ST_SERVE;
               ball_reset_d = 1'b1;
               cnt_d        = '0;
            end
         end
         ST_SERVE: begin
            cnt_d = cnt_inc;
            if (start_evt_q || (cnt_inc >= c_SERVE)) begin
               state_d = ST_PLAY;
               cnt_d   = '0;
            end
         end
         ST_PLAY: begin
            // Brick first, then win, then ball loss, then pause
            if (brick_hit && (bricks_q != 8'd0)) begin
               bricks_d = bricks_q - 8'd1;
               score_d  = score_sat;
            end
            if (brick_hit && (bricks_q == 8'd1)) begin
               state_d = ST_WIN;
            end else if (ball_lost) begin
               if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
               if (lives_q <= 3'd1) begin
                  state_d = ST_OVER;
               end else begin
                  state_d = ST_LOST;
                  cnt_d   = '0;
               end
            end else if (pause_sw) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (!pause_sw) state_d = ST_PLAY;
         end
         ST_LOST: begin
            cnt_d = cnt_inc;
            if (cnt_inc >= c_HOLD) begin
               state_d      = ST_SERVE;
               ball_reset_d = 1'b1;
               cnt_d        = '0;
            end
         end
         ST_OVER, ST_WIN: begin
            if (start_evt_q) state_d = ST_ATTRACT;
         end
         default: begin
            state_d = ST_ATTRACT;
         end
      endcase
      paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
      ball_en_d   = (state_d == ST_PLAY);
   end

   // Game state and scoreboard registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_ATTRACT;
         cnt_q        <= '0;
         lives_q      <= c_LIVES;
         score_q      <= '0;
         bricks_q     <= c_BRICKS;
         ball_reset_q <= 1'b0;
         paddle_en_q  <= 1'b0;
         ball_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         lives_q      <= lives_d;
         score_q      <= score_d;
         bricks_q     <= bricks_d;
         ball_reset_q <= ball_reset_d;
         paddle_en_q  <= paddle_en_d;
         ball_en_q    <= ball_en_d;
      end
   end

`ifdef HIGH_SCORE_EN
   logic [15:0] high_score_q;

   // Record the final score of a finished game if it beats the best so far
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         high_score_q <= '0;
      end else if ((state_q == ST_PLAY) &&
                   ((state_d == ST_OVER) || (state_d == ST_WIN)) &&
                   (score_d > high_score_q)) begin
         high_score_q <= score_d;
      end
   end

   assign high_score = high_score_q;
`else
   assign high_score = 16'd0;
`endif

   assign frame_tick  = frame_tick_q;
   assign paddle_en   = paddle_en_q;
   assign ball_en     = ball_en_q;
   assign ball_reset  = ball_reset_q;
   assign game_state  = state_q;
   assign lives       = lives_q;
   assign score       = score_q;
   assign bricks_left = bricks_q;

endmodule
`default_nettype wire

// File: tb/tb_game_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_seq_ctrl
// Brief    : Directed self-checking bench for game_seq_ctrl with small
//            parameters (4-clock frame, 2 lives, 4 bricks, 2-tick serve/hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_seq_ctrl;

   localparam logic [2:0] S_ATTRACT = 3'd0;
   localparam logic [2:0] S_SERVE   = 3'd1;
   localparam logic [2:0] S_PLAY    = 3'd2;
   localparam logic [2:0] S_PAUSE   = 3'd3;
   localparam logic [2:0] S_LOST    = 3'd4;
   localparam logic [2:0] S_OVER    = 3'd5;
   localparam logic [2:0] S_WIN     = 3'd6;

   logic        clk;
   logic        rst;
   logic        start_n;
   logic        pause_sw;
   logic        brick_hit;
   logic        ball_lost;
   logic        frame_tick;
   logic        paddle_en;
   logic        ball_en;
   logic        ball_reset;
   logic [2:0]  game_state;
   logic [2:0]  lives;
   logic [15:0] score;
   logic [7:0]  bricks_left;
   logic [15:0] high_score;

   int checks = 0;
   int errors = 0;
   int br_pulses = 0;
   int serve_ft  = 0;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [2:0] lv;
      logic [15:0] sc;
      logic [7:0] br;
   } exp_t;

   exp_t sb_q[$];

   game_seq_ctrl #(
      .TICK_DIV    (4),
      .LIVES_INIT  (2),
      .BRICK_COUNT (4),
      .SERVE_TICKS (2),
      .HOLD_TICKS  (2),
      .BRICK_POINTS(10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_n    (start_n),
      .pause_sw   (pause_sw),
      .brick_hit  (brick_hit),
      .ball_lost  (ball_lost),
      .frame_tick (frame_tick),
      .paddle_en  (paddle_en),
      .ball_en    (ball_en),
      .ball_reset (ball_reset),
      .game_state (game_state),
      .lives      (lives),
      .score      (score),
      .bricks_left(bricks_left),
      .high_score (high_score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count ball_reset pulses and frame ticks seen while serving
   always @(negedge clk) begin
      if (ball_reset) br_pulses <= br_pulses + 1;
      if ((game_state == S_SERVE) && frame_tick) serve_ft <= serve_ft + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for a state; an expired budget shows as a failed check
   task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (game_state == target) break;
         tick();
      end
      check(tag, 32'(game_state), 32'(target));
   endtask

   // One PLAY-phase step: drive inputs, queue expectation, compare after edge
   task automatic step(input logic h, input logic l, input logic p, input string tag,
                       input logic [2:0] st, input logic [2:0] lv,
                       input logic [15:0] sc, input logic [7:0] br);
      exp_t e;
      e.tag = tag; e.st = st; e.lv = lv; e.sc = sc; e.br = br;
      brick_hit = h;
      ball_lost = l;
      pause_sw  = p;
      sb_q.push_back(e);
      tick();
      brick_hit = 1'b0;
      ball_lost = 1'b0;
      e = sb_q.pop_front();
      check({e.tag, "_state"},  32'(game_state),  32'(e.st));
      check({e.tag, "_lives"},  32'(lives),       32'(e.lv));
      check({e.tag, "_score"},  32'(score),       32'(e.sc));
      check({e.tag, "_bricks"}, 32'(bricks_left), 32'(e.br));
      check({e.tag, "_pen"},    32'(paddle_en),   32'((e.st == S_SERVE) || (e.st == S_PLAY)));
      check({e.tag, "_ben"},    32'(ball_en),     32'(e.st == S_PLAY));
   endtask

   task automatic start_game(input string tag);
      start_n = 1'b0;
      repeat (10) tick();
      start_n = 1'b1;
      wait_state(tag, S_PLAY, 20);
   endtask

   task automatic end_to_attract(input string tag);
      start_n = 1'b0;
      wait_state(tag, S_ATTRACT, 8);
      start_n = 1'b1;
      tick();
      check({tag, "_lives"},  32'(lives),       32'd2);
      check({tag, "_score"},  32'(score),       32'd0);
      check({tag, "_bricks"}, 32'(bricks_left), 32'd4);
      check({tag, "_ben"},    32'(ball_en),     32'd0);
      repeat (3) tick();
   endtask

   function automatic logic [31:0] hs_exp(input logic [31:0] v);
`ifdef HIGH_SCORE_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   initial begin
      int b0;
      int f0;
      rst       = 1'b0;
      start_n   = 1'b1;
      pause_sw  = 1'b0;
      brick_hit = 1'b0;
      ball_lost = 1'b0;
      repeat (3) tick();

      // Reset values
      check("rst_state",  32'(game_state),  32'(S_ATTRACT));
      check("rst_lives",  32'(lives),       32'd2);
      check("rst_score",  32'(score),       32'd0);
      check("rst_bricks", 32'(bricks_left), 32'd4);
      check("rst_ftick",  32'(frame_tick),  32'd0);
      check("rst_pen",    32'(paddle_en),   32'd0);
      check("rst_ben",    32'(ball_en),     32'd0);
      check("rst_breset", 32'(ball_reset),  32'd0);
      check("rst_hscore", 32'(high_score),  32'd0);

      // Frame tick at cycles 3, 7, 11 after release
      rst = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         check($sformatf("ftick_c%0d", i), 32'(frame_tick), 32'((i % 4) == 3));
      end

      // Game 1: start held 10 cycles, auto-launch after two serve ticks
      b0 = br_pulses;
      f0 = serve_ft;
      start_n = 1'b0;
      wait_state("g1_serve", S_SERVE, 8);
      repeat (6) tick();
      start_n = 1'b1;
      wait_state("g1_play", S_PLAY, 20);
      check("g1_play_ben",   32'(ball_en),      32'd1);
      check("g1_play_pen",   32'(paddle_en),    32'd1);
      check("g1_serve_ft",   32'(serve_ft - f0), 32'd2);
      check("g1_one_breset", 32'(br_pulses - b0), 32'd1);

      step(1'b1, 1'b0, 1'b0, "g1_hit1",   S_PLAY,  3'd2, 16'd10, 8'd3);
      step(1'b0, 1'b0, 1'b1, "g1_pause",  S_PAUSE, 3'd2, 16'd10, 8'd3);
      step(1'b1, 1'b0, 1'b1, "g1_p_hit",  S_PAUSE, 3'd2, 16'd10, 8'd3);
      step(1'b0, 1'b1, 1'b1, "g1_p_lost", S_PAUSE, 3'd2, 16'd10, 8'd3);
      step(1'b0, 1'b0, 1'b0, "g1_resume", S_PLAY,  3'd2, 16'd10, 8'd3);
      step(1'b1, 1'b0, 1'b0, "g1_hit2",   S_PLAY,  3'd2, 16'd20, 8'd2);
      b0 = br_pulses;
      step(1'b0, 1'b1, 1'b0, "g1_lost1",  S_LOST,  3'd1, 16'd20, 8'd2);
      wait_state("g1_reserve", S_SERVE, 20);

      // Early launch by button before the serve timer expires
      f0 = serve_ft;
      start_n = 1'b0;
      wait_state("g1_launch", S_PLAY, 6);
      start_n = 1'b1;
      check("g1_launch_early", 32'((serve_ft - f0) < 2), 32'd1);
      check("g1_hold_breset",  32'(br_pulses - b0), 32'd1);
      step(1'b1, 1'b0, 1'b0, "g1_hit3", S_PLAY, 3'd1, 16'd30, 8'd1);

      // Asynchronous reset mid-game
      rst = 1'b0;
      #1;
      check("midrst_state",  32'(game_state),  32'(S_ATTRACT));
      check("midrst_score",  32'(score),       32'd0);
      check("midrst_lives",  32'(lives),       32'd2);
      check("midrst_bricks", 32'(bricks_left), 32'd4);
      check("midrst_ben",    32'(ball_en),     32'd0);
      tick();
      rst = 1'b1;
      repeat (3) tick();

      // Game 2: game over at score 30
      start_game("g2_play");
      step(1'b1, 1'b0, 1'b0, "g2_hit1",  S_PLAY, 3'd2, 16'd10, 8'd3);
      step(1'b1, 1'b0, 1'b0, "g2_hit2",  S_PLAY, 3'd2, 16'd20, 8'd2);
      step(1'b1, 1'b0, 1'b0, "g2_hit3",  S_PLAY, 3'd2, 16'd30, 8'd1);
      step(1'b0, 1'b1, 1'b0, "g2_lost1", S_LOST, 3'd1, 16'd30, 8'd1);
      wait_state("g2_reserve", S_SERVE, 20);
      wait_state("g2_replay",  S_PLAY, 20);
      step(1'b0, 1'b1, 1'b0, "g2_lost2", S_OVER, 3'd0, 16'd30, 8'd1);
      check("g2_hscore", 32'(high_score), hs_exp(32'd30));
      step(1'b1, 1'b1, 1'b1, "g2_over_ignore", S_OVER, 3'd0, 16'd30, 8'd1);
      end_to_attract("g2_attract");
      check("g2_hscore_kept", 32'(high_score), hs_exp(32'd30));

      // Game 3: game over at score 20, record stays 30
      start_game("g3_play");
      step(1'b1, 1'b0, 1'b0, "g3_hit1",  S_PLAY, 3'd2, 16'd10, 8'd3);
      step(1'b1, 1'b0, 1'b0, "g3_hit2",  S_PLAY, 3'd2, 16'd20, 8'd2);
      step(1'b0, 1'b1, 1'b0, "g3_lost1", S_LOST, 3'd1, 16'd20, 8'd2);
      wait_state("g3_reserve", S_SERVE, 20);
      wait_state("g3_replay",  S_PLAY, 20);
      step(1'b0, 1'b1, 1'b0, "g3_lost2", S_OVER, 3'd0, 16'd20, 8'd2);
      check("g3_hscore", 32'(high_score), hs_exp(32'd30));
      end_to_attract("g3_attract");

      // Game 4: last brick coincident with ball loss wins, lives unchanged
      start_game("g4_play");
      step(1'b1, 1'b0, 1'b0, "g4_hit1",  S_PLAY, 3'd2, 16'd10, 8'd3);
      step(1'b1, 1'b0, 1'b0, "g4_hit2",  S_PLAY, 3'd2, 16'd20, 8'd2);
      step(1'b1, 1'b0, 1'b0, "g4_hit3",  S_PLAY, 3'd2, 16'd30, 8'd1);
      step(1'b1, 1'b1, 1'b0, "g4_coinc", S_WIN,  3'd2, 16'd40, 8'd0);
      step(1'b1, 1'b0, 1'b0, "g4_win_ignore", S_WIN, 3'd2, 16'd40, 8'd0);
      check("g4_hscore", 32'(high_score), hs_exp(32'd40));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
